msrv32_wb_unit: RTL and testbench
=================================

MSRV32_WB_UNIT -- requirements
Module: msrv32_wb_unit

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset.
REQ-002 SHALL have these ports:
- ms_riscv32_mp_clk_in  input  1  clock; all state changes on rising edge.
- ms_riscv32_mp_rst_in  input  1  synchronous active-high reset.
- valid_in  input  1  execute-stage instruction valid.
- wr_en_in  input  1  instruction writes rd.
- rd_addr_in  input  5  destination register.
- wb_mux_sel_in  input  3  source: 000 ALU, 001 load, 010 imm, 011 PC+4, 100 CSR.
- alu_result_in  input  32  ALU result; bits [1:0] are the load byte offset.
- imm_in  input  32  immediate (LUI).
- pc_plus_4_in  input  32  link value (JAL/JALR).
- csr_data_in  input  32  CSR read data.
- load_size_in  input  2  00 byte, 01 half, 10/11 word.
- load_unsigned_in  input  1  zero-extend load.
- ms_riscv32_mp_dmdata_in  input  32  data memory read word.
- ms_riscv32_mp_dmdata_valid_in  input  1  read data valid strobe.
- stall_out  output  1  hold upstream stage.
- rf_wr_en_out  output  1  register-file write enable.
- rf_rd_addr_out  output  5  register-file write address.
- rf_rd_out  output  32  register-file write data.
- load_misaligned_out  output  1  one-cycle misaligned-load pulse.
- load_fault_out  output  1  one-cycle load-timeout pulse.

Function
REQ-003 SHALL implement a two-state FSM: IDLE and WAIT_LOAD.
REQ-004 SHALL drive stall_out combinationally high exactly while the state is WAIT_LOAD.
REQ-005 In IDLE, valid_in=1 with wr_en_in=1 and a non-load source SHALL produce, at the next edge, rf_wr_en_out=1, rf_rd_addr_out=rd_addr_in, and rf_rd_out set to the selected source (latency 1).
REQ-006 SHALL make rf_wr_en_out a single-cycle pulse and SHALL hold rf_rd_addr_out and rf_rd_out until the next write.
REQ-007 SHALL treat wb_mux_sel_in values 101–111 as ALU.
REQ-008 SHALL never assert rf_wr_en_out for rd_addr 0.
REQ-009 In IDLE, an aligned load with valid_in=1 and wr_en_in=1 SHALL capture rd_addr, offset, size and unsigned, then enter WAIT_LOAD at the next edge.
REQ-010 A misaligned load (half with offset[0]=1, or word with offset≠0) SHALL pulse load_misaligned_out for one cycle, stay in IDLE and never write.
REQ-011 In WAIT_LOAD, dmdata_valid_in=1 SHALL return the FSM to IDLE and, at that same edge, write the aligned, extended data (rf_wr_en_out=1 next cycle).
REQ-012 Byte alignment SHALL select data[8*off+7:8*off]; half SHALL select off[1] ? [31:16] : [15:0]; both SHALL sign-extend unless load_unsigned is set; word SHALL pass unchanged.
REQ-013 A load to x0 SHALL still wait for dmdata_valid_in but SHALL never write.
REQ-014 SHALL ignore valid_in while in WAIT_LOAD, and SHALL ignore dmdata_valid_in while in IDLE.
REQ-015 SHALL ignore valid_in=0 and wr_en_in=0 instructions: no write and no state change.

Reset
REQ-016 Reset SHALL force state IDLE and drive rf_wr_en_out=0, rf_rd_addr_out=0, rf_rd_out=0, load_misaligned_out=0, load_fault_out=0 and the timeout counter to 0.
REQ-017 Reset asserted during WAIT_LOAD SHALL abandon the pending load with no write, even if dmdata_valid_in is high in the same cycle.

Configuration
REQ-018 With macro MSRV32_WB_LOAD_TIMEOUT_EN defined, SHALL count cycles in WAIT_LOAD with a 4-bit counter.
REQ-019 With the macro defined, when 16 consecutive WAIT_LOAD cycles pass without dmdata_valid_in, SHALL pulse load_fault_out, return to IDLE, skip the write and clear the counter.
REQ-020 With the macro defined, dmdata_valid_in on the 16th cycle SHALL take priority, so the write occurs and no fault is raised.
REQ-021 Without the macro, SHALL wait indefinitely in WAIT_LOAD, tie load_fault_out to 0 and omit the counter.

Verification
REQ-022 ALU write: valid, wr_en, sel=000, rd=5, alu=0x1234 -> next cycle rf_wr_en_out=1, addr=5, data=0x00001234.
REQ-023 Signed byte load: offset 3, size 00, signed, memory returns 0x80FF0000 after 3 cycles -> stall_out high for 3 cycles, then write 0xFFFFFF80.
REQ-024 Misaligned load: half with offset 1 -> load_misaligned_out=1 for one cycle, no write, stall_out stays 0.
REQ-025 x0 suppression: sel=011, rd=0, pc_plus_4=0x104 -> rf_wr_en_out remains 0.
REQ-026 Reset mid-load: reset in cycle 2 of WAIT_LOAD with dmdata_valid_in=1 -> state IDLE, no write, all outputs 0.
REQ-027 Timeout (macro defined): no valid for 16 cycles -> load_fault_out pulses once, stall_out drops, no write.

Source files
------------

// File: rtl/msrv32_wb_unit.sv
// Write-back unit: selects the register-file write source and waits for load data.
// Optional load timeout is enabled by defining MSRV32_WB_LOAD_TIMEOUT_EN.
module msrv32_wb_unit (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic        valid_in,
  input  logic        wr_en_in,
  input  logic [4:0]  rd_addr_in,
  input  logic [2:0]  wb_mux_sel_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] imm_in,
  input  logic [31:0] pc_plus_4_in,
  input  logic [31:0] csr_data_in,
  input  logic [1:0]  load_size_in,
  input  logic        load_unsigned_in,
  input  logic [31:0] ms_riscv32_mp_dmdata_in,
  input  logic        ms_riscv32_mp_dmdata_valid_in,
  output logic        stall_out,
  output logic        rf_wr_en_out,
  output logic [4:0]  rf_rd_addr_out,
  output logic [31:0] rf_rd_out,
  output logic        load_misaligned_out,
  output logic        load_fault_out
);

  typedef enum logic {StIdle, StWaitLoad} state_e;

  state_e      state_q;
  logic        rf_wr_en_q;
  logic [4:0]  rf_rd_addr_q;
  logic [31:0] rf_rd_q;
  logic        misaligned_q;
  logic [4:0]  ld_rd_q;
  logic [1:0]  ld_off_q;
  logic [1:0]  ld_size_q;
  logic        ld_uns_q;

  logic [31:0] src_data;
  logic [31:0] load_data;
  logic        is_load;
  logic        misaligned;

  function automatic logic [31:0] align_load(input logic [31:0] word, input logic [1:0] off,
                                             input logic [1:0] size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   res = {{24{~uns & b[7]}}, b};
      2'b01:   res = {{16{~uns & h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  always_comb begin
    src_data = alu_result_in;
    case (wb_mux_sel_in)
      3'b010:  src_data = imm_in;
      3'b011:  src_data = pc_plus_4_in;
      3'b100:  src_data = csr_data_in;
      default: src_data = alu_result_in;
    endcase
  end

  assign is_load    = (wb_mux_sel_in == 3'b001);
  // Bytes are always aligned; halves need an even offset; words need offset 0.
  assign misaligned = ((load_size_in == 2'b01) && alu_result_in[0]) ||
                      (load_size_in[1] && (alu_result_in[1:0] != 2'b00));
  assign load_data  = align_load(ms_riscv32_mp_dmdata_in, ld_off_q, ld_size_q, ld_uns_q);

  assign stall_out           = (state_q == StWaitLoad);
  assign rf_wr_en_out        = rf_wr_en_q;
  assign rf_rd_addr_out      = rf_rd_addr_q;
  assign rf_rd_out           = rf_rd_q;
  assign load_misaligned_out = misaligned_q;

`ifdef MSRV32_WB_LOAD_TIMEOUT_EN
  logic [3:0] tmo_cnt_q;
  logic       fault_q;
  assign load_fault_out = fault_q;
`else
  assign load_fault_out = 1'b0;
`endif

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state_q      <= StIdle;
      rf_wr_en_q   <= 1'b0;
      rf_rd_addr_q <= 5'd0;
      rf_rd_q      <= 32'd0;
      misaligned_q <= 1'b0;
      ld_rd_q      <= 5'd0;
      ld_off_q     <= 2'd0;
      ld_size_q    <= 2'd0;
      ld_uns_q     <= 1'b0;
`ifdef MSRV32_WB_LOAD_TIMEOUT_EN
      tmo_cnt_q    <= 4'd0;
      fault_q      <= 1'b0;
`endif
    end else begin
      rf_wr_en_q   <= 1'b0;
      misaligned_q <= 1'b0;
`ifdef MSRV32_WB_LOAD_TIMEOUT_EN
      fault_q      <= 1'b0;
`endif
      case (state_q)
        StIdle: begin
          if (valid_in && wr_en_in) begin
            if (is_load) begin
              if (misaligned) begin
                misaligned_q <= 1'b1;
              end else begin
                state_q   <= StWaitLoad;
                ld_rd_q   <= rd_addr_in;
                ld_off_q  <= alu_result_in[1:0];
                ld_size_q <= load_size_in;
                ld_uns_q  <= load_unsigned_in;
`ifdef MSRV32_WB_LOAD_TIMEOUT_EN
                tmo_cnt_q <= 4'd0;
`endif
              end
            end else if (rd_addr_in != 5'd0) begin
              rf_wr_en_q   <= 1'b1;
              rf_rd_addr_q <= rd_addr_in;
              rf_rd_q      <= src_data;
            end
          end
        end
        StWaitLoad: begin
          // Data arriving on the last permitted cycle wins over the timeout.
          if (ms_riscv32_mp_dmdata_valid_in) begin
            state_q <= StIdle;
            if (ld_rd_q != 5'd0) begin
              rf_wr_en_q   <= 1'b1;
              rf_rd_addr_q <= ld_rd_q;
              rf_rd_q      <= load_data;
            end
`ifdef MSRV32_WB_LOAD_TIMEOUT_EN
            tmo_cnt_q <= 4'd0;
          end else if (tmo_cnt_q == 4'd15) begin
            state_q   <= StIdle;
            fault_q   <= 1'b1;
            tmo_cnt_q <= 4'd0;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 4'd1;
`endif
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_msrv32_wb_unit.sv
// Self-checking bench for msrv32_wb_unit: directed cases then random traffic vs a behavioural model.
module tb_msrv32_wb_unit;

  logic        clk = 1'b0;
  logic        rst, valid, wr_en, luns, dmv;
  logic [4:0]  rd;
  logic [2:0]  sel;
  logic [1:0]  lsize;
  logic [31:0] alu, imm, pc4, csr, dm;
  logic        stall, rf_wr, mis, fault;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;

  int tests = 0;
  int fails = 0;

  // Behavioural model: a pending-load record plus expected outputs.
  bit          pend;
  logic [4:0]  p_rd;
  int unsigned p_off, p_size;
  bit          p_uns;
  int          waited;
  bit          e_wr, e_mis, e_fault;
  logic [4:0]  e_addr;
  logic [31:0] e_data;

  msrv32_wb_unit dut (
    .ms_riscv32_mp_clk_in          (clk),
    .ms_riscv32_mp_rst_in          (rst),
    .valid_in                      (valid),
    .wr_en_in                      (wr_en),
    .rd_addr_in                    (rd),
    .wb_mux_sel_in                 (sel),
    .alu_result_in                 (alu),
    .imm_in                        (imm),
    .pc_plus_4_in                  (pc4),
    .csr_data_in                   (csr),
    .load_size_in                  (lsize),
    .load_unsigned_in              (luns),
    .ms_riscv32_mp_dmdata_in       (dm),
    .ms_riscv32_mp_dmdata_valid_in (dmv),
    .stall_out                     (stall),
    .rf_wr_en_out                  (rf_wr),
    .rf_rd_addr_out                (rf_addr),
    .rf_rd_out                     (rf_data),
    .load_misaligned_out           (mis),
    .load_fault_out                (fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] extract(input logic [31:0] w, input int unsigned off,
                                          input int unsigned size, input bit uns);
    longint v;
    if (size == 0) begin
      v = longint'((w >> (8 * off)) & 32'hFF);
      if (!uns && v >= 128) v = v - 256;
    end else if (size == 1) begin
      v = longint'((w >> (off >= 2 ? 16 : 0)) & 32'hFFFF);
      if (!uns && v >= 32768) v = v - 65536;
    end else begin
      v = longint'(w);
    end
    return v[31:0];
  endfunction

  task automatic model();
    int unsigned off;
    bit          bad;
    e_wr = 0; e_mis = 0; e_fault = 0;
    if (rst) begin
      pend = 0; waited = 0; e_addr = 0; e_data = 0;
    end else if (!pend) begin
      if (valid && wr_en) begin
        if (sel == 3'd1) begin
          off = int'(alu & 32'h3);
          bad = (lsize == 2'd1 && (off % 2) == 1) || (lsize >= 2'd2 && off != 0);
          if (bad) e_mis = 1;
          else begin
            pend = 1; waited = 0; p_rd = rd; p_off = off; p_size = lsize; p_uns = luns;
          end
        end else if (rd != 0) begin
          e_wr = 1; e_addr = rd;
          e_data = (sel == 3'd2) ? imm : (sel == 3'd3) ? pc4 : (sel == 3'd4) ? csr : alu;
        end
      end
    end else if (dmv) begin
      pend = 0;
      if (p_rd != 0) begin
        e_wr = 1; e_addr = p_rd; e_data = extract(dm, p_off, p_size > 1 ? 2 : p_size, p_uns);
      end
    end else begin
      waited++;
`ifdef MSRV32_WB_LOAD_TIMEOUT_EN
      if (waited == 16) begin
        pend = 0; e_fault = 1;
      end
`endif
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    model();
    @(posedge clk);
    #1;
    check("stall",  32'(stall),   32'(pend));
    check("wr_en",  32'(rf_wr),   32'(e_wr));
    check("addr",   32'(rf_addr), 32'(e_addr));
    check("data",   rf_data,      e_data);
    check("misal",  32'(mis),     32'(e_mis));
    check("fault",  32'(fault),   32'(e_fault));
  endtask

  task automatic issue(input logic [2:0] s, input logic [4:0] r, input logic [31:0] a,
                       input logic [1:0] sz, input logic u);
    valid = 1; wr_en = 1; sel = s; rd = r; alu = a; lsize = sz; luns = u; dmv = 0;
    step();
    valid = 0; wr_en = 0;
  endtask

  task automatic idle(input int n);
    dmv = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic mem(input logic [31:0] d);
    dm = d; dmv = 1;
    step();
    dmv = 0;
  endtask

  initial begin
    rst = 1; valid = 0; wr_en = 0; rd = 0; sel = 0; alu = 0; imm = 0; pc4 = 0; csr = 0;
    lsize = 0; luns = 0; dm = 0; dmv = 0;
    pend = 0; waited = 0; e_addr = 0; e_data = 0;
    step();
    step();
    check("rst_wr", 32'(rf_wr), 32'd0);
    check("rst_data", rf_data, 32'd0);
    rst = 0;

    // ALU write
    issue(3'b000, 5'd5, 32'h1234, 2'b00, 1'b0);
    check("alu_wr", 32'(rf_wr), 32'd1);
    check("alu_data", rf_data, 32'h0000_1234);
    idle(1);
    check("wr_pulse", 32'(rf_wr), 32'd0);
    check("hold_data", rf_data, 32'h0000_1234);

    // Other sources, including reserved selects treated as ALU
    imm = 32'hABCD_E000; pc4 = 32'h0000_0200; csr = 32'h5A5A_0001;
    issue(3'b010, 5'd1, 32'h11, 2'b00, 1'b0);
    check("imm_data", rf_data, 32'hABCD_E000);
    issue(3'b011, 5'd2, 32'h22, 2'b00, 1'b0);
    issue(3'b100, 5'd3, 32'h33, 2'b00, 1'b0);
    issue(3'b111, 5'd4, 32'h44, 2'b00, 1'b0);
    check("sel7_alu", rf_data, 32'h44);

    // Signed byte load, offset 3, three wait cycles
    issue(3'b001, 5'd7, 32'h1003, 2'b00, 1'b0);
    check("ld_stall1", 32'(stall), 32'd1);
    idle(2);
    check("ld_stall3", 32'(stall), 32'd1);
    mem(32'h80FF_0000);
    check("ld_data", rf_data, 32'hFFFF_FF80);
    check("ld_stall_drop", 32'(stall), 32'd0);

    // Misaligned half
    issue(3'b001, 5'd9, 32'h1, 2'b01, 1'b0);
    check("misal_pulse", 32'(mis), 32'd1);
    check("misal_nostall", 32'(stall), 32'd0);
    idle(1);

    // x0 suppression
    pc4 = 32'h104;
    issue(3'b011, 5'd0, 32'h0, 2'b00, 1'b0);
    check("x0_wr", 32'(rf_wr), 32'd0);

    // Load to x0 waits but never writes; dmdata_valid in IDLE is ignored
    issue(3'b001, 5'd0, 32'h2, 2'b01, 1'b1);
    idle(1);
    mem(32'h1234_5678);
    mem(32'h9999_9999);

    // Reset during the second WAIT_LOAD cycle with data valid
    issue(3'b001, 5'd8, 32'h0, 2'b10, 1'b0);
    idle(1);
    rst = 1;
    mem(32'hDEAD_BEEF);
    rst = 0;
    check("rstld_stall", 32'(stall), 32'd0);
    check("rstld_wr", 32'(rf_wr), 32'd0);
    check("rstld_data", rf_data, 32'd0);

    // Long wait: times out with the macro, otherwise waits for data
    issue(3'b001, 5'd12, 32'h0, 2'b10, 1'b0);
    idle(20);
`ifdef MSRV32_WB_LOAD_TIMEOUT_EN
    check("tmo_stall", 32'(stall), 32'd0);
`else
    check("tmo_stall", 32'(stall), 32'd1);
`endif
    mem(32'h0BAD_F00D);

    // Data on the 16th wait cycle always writes
    issue(3'b001, 5'd13, 32'h2, 2'b01, 1'b1);
    idle(15);
    mem(32'hCAFE_F00D);
    check("prio_wr", 32'(rf_wr), 32'd1);
    check("prio_data", rf_data, 32'h0000_CAFE);
    check("prio_fault", 32'(fault), 32'd0);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      rst   = ($urandom_range(0, 49) == 0);
      valid = ($urandom_range(0, 3) != 0);
      wr_en = ($urandom_range(0, 4) != 0);
      rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      sel   = ($urandom_range(0, 1) == 0) ? 3'd1 : 3'($urandom);
      alu   = $urandom; imm = $urandom; pc4 = $urandom; csr = $urandom; dm = $urandom;
      lsize = 2'($urandom);
      luns  = 1'($urandom);
      dmv   = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
